// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises rx, qualifies the start bit, strobes
// mid-bit data samples into an external shift register and checks the stop bit.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic shreg_clr,
  output logic shift_en,
  output logic shift_bit,
  output logic busy,
  output logic data_valid,
  output logic frame_err
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [IDX_W-1:0] r_bit_idx;
  logic             r_rx_m;
  logic             r_rx_s;
  logic             r_shreg_clr;
  logic             r_shift_en;
  logic             r_shift_bit;
  logic             r_busy;
  logic             r_data_valid;
  logic             r_frame_err;

  // Sequencer: busy is updated together with the state so it mirrors state != IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_bit_idx    <= '0;
      r_rx_m       <= 1'b1;
      r_rx_s       <= 1'b1;
      r_shreg_clr  <= 1'b0;
      r_shift_en   <= 1'b0;
      r_shift_bit  <= 1'b0;
      r_busy       <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_m       <= rx;
      r_rx_s       <= r_rx_m;
      r_shreg_clr  <= 1'b0;
      r_shift_en   <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_timer <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_timer == HALF_LAST) begin
            r_timer <= '0;
            if (!r_rx_s) begin
              r_state     <= S_DATA;
              r_bit_idx   <= '0;
              r_shreg_clr <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (r_timer == BIT_LAST) begin
            r_timer     <= '0;
            r_shift_en  <= 1'b1;
            r_shift_bit <= r_rx_s;
            r_bit_idx   <= r_bit_idx + IDX_W'(1);
            if (r_bit_idx == IDX_LAST) begin
              r_state   <= S_STOP;
              r_bit_idx <= '0;
            end
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (r_timer == BIT_LAST) begin
            r_timer <= '0;
            if (r_rx_s) begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_data_valid <= 1'b1;
            end else begin
              r_state     <= S_BREAK;
              r_frame_err <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end

        S_BREAK: begin
          // Line held low after a bad stop bit: wait for it to return high.
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign shreg_clr  = r_shreg_clr;
  assign shift_en   = r_shift_en;
  assign shift_bit  = r_shift_bit;
  assign busy       = r_busy;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a 16-clk/8-bit instance and a 4-clk/7-bit instance.
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic rx_a, rx_b;

  logic a_shreg_clr, a_shift_en, a_shift_bit, a_busy, a_data_valid, a_frame_err;
  logic b_shreg_clr, b_shift_en, b_shift_bit, b_busy, b_data_valid, b_frame_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int a_clr = 0, a_dv = 0, a_fe = 0, a_excl = 0, a_clr_cyc = 0, a_dv_cyc = 0;
  int b_clr = 0, b_dv = 0, b_fe = 0, b_excl = 0, b_clr_cyc = 0, b_dv_cyc = 0;
  int   a_sh_cyc[$];
  logic a_sh_bit[$];
  int   b_sh_cyc[$];
  logic b_sh_bit[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8), .CNT_W(8)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx_a),
    .shreg_clr  (a_shreg_clr),
    .shift_en   (a_shift_en),
    .shift_bit  (a_shift_bit),
    .busy       (a_busy),
    .data_valid (a_data_valid),
    .frame_err  (a_frame_err)
  );

  uart_rx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(7), .CNT_W(4)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx_b),
    .shreg_clr  (b_shreg_clr),
    .shift_en   (b_shift_en),
    .shift_bit  (b_shift_bit),
    .busy       (b_busy),
    .data_valid (b_data_valid),
    .frame_err  (b_frame_err)
  );

  // Pulse recorder, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (a_shreg_clr === 1'b1) begin a_clr++; a_clr_cyc = cyc; end
    if (a_shift_en === 1'b1) begin a_sh_cyc.push_back(cyc); a_sh_bit.push_back(a_shift_bit); end
    if (a_data_valid === 1'b1) begin a_dv++; a_dv_cyc = cyc; end
    if (a_frame_err === 1'b1) a_fe++;
    if ($countones({a_shreg_clr, a_shift_en, a_data_valid, a_frame_err}) > 1) a_excl++;
    if (b_shreg_clr === 1'b1) begin b_clr++; b_clr_cyc = cyc; end
    if (b_shift_en === 1'b1) begin b_sh_cyc.push_back(cyc); b_sh_bit.push_back(b_shift_bit); end
    if (b_data_valid === 1'b1) begin b_dv++; b_dv_cyc = cyc; end
    if (b_frame_err === 1'b1) b_fe++;
    if ($countones({b_shreg_clr, b_shift_en, b_data_valid, b_frame_err}) > 1) b_excl++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one line level for n clocks; always called on a falling edge.
  task automatic drive(input int which, input logic v, input int n);
    if (which == 0) rx_a = v;
    else rx_b = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                            input logic stop, input int cpb);
    drive(which, 1'b0, cpb);
    for (int i = 0; i < nbits; i++) drive(which, data[i], cpb);
    drive(which, stop, cpb);
  endtask

  function automatic logic [7:0] bits_of(input int which, input int base, input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r[i] = (which == 0) ? a_sh_bit[base+i] : b_sh_bit[base+i];
    return r;
  endfunction

  function automatic int bad_gaps(input int which, input int base, input int n, input int gap);
    int bad;
    int d;
    bad = 0;
    for (int i = 1; i < n; i++) begin
      d = (which == 0) ? a_sh_cyc[base+i] - a_sh_cyc[base+i-1]
                       : b_sh_cyc[base+i] - b_sh_cyc[base+i-1];
      if (d != gap) bad++;
    end
    return bad;
  endfunction

  function automatic logic [5:0] outs_a();
    return {a_shreg_clr, a_shift_en, a_shift_bit, a_busy, a_data_valid, a_frame_err};
  endfunction

  initial begin
    int sb, c0, d0, f0;
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs_a", 32'(outs_a()), 32'h0);
    check("reset_outs_b", 32'({b_shreg_clr, b_shift_en, b_shift_bit, b_busy, b_data_valid, b_frame_err}), 32'h0);
    reset = 1'b0;
    drive(0, 1'b1, 5);

    // Frame 0xA5, good stop
    sb = a_sh_cyc.size(); c0 = a_clr; d0 = a_dv; f0 = a_fe;
    send_frame(0, 8'hA5, 8, 1'b1, 16);
    drive(0, 1'b1, 8);
    check("a5_clr", 32'(a_clr - c0), 32'd1);
    check("a5_nshift", 32'(a_sh_cyc.size() - sb), 32'd8);
    check("a5_bits", 32'(bits_of(0, sb, 8)), 32'hA5);
    check("a5_gaps", 32'(bad_gaps(0, sb, 8, 16)), 32'd0);
    check("a5_first_lat", 32'(a_sh_cyc[sb] - a_clr_cyc), 32'd16);
    check("a5_dv", 32'(a_dv - d0), 32'd1);
    check("a5_dv_lat", 32'(a_dv_cyc - a_sh_cyc[sb+7]), 32'd16);
    check("a5_fe", 32'(a_fe - f0), 32'd0);
    check("a5_busy_idle", 32'(a_busy), 32'd0);

    // Start glitch: 4 clk low
    sb = a_sh_cyc.size(); c0 = a_clr;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 2);
    check("glitch_busy_hi", 32'(a_busy), 32'd1);
    drive(0, 1'b1, 10);
    check("glitch_busy_lo", 32'(a_busy), 32'd0);
    check("glitch_clr", 32'(a_clr - c0), 32'd0);
    check("glitch_shift", 32'(a_sh_cyc.size() - sb), 32'd0);

    // Frame 0x3C with low stop, line held low, then released
    sb = a_sh_cyc.size(); d0 = a_dv; f0 = a_fe;
    send_frame(0, 8'h3C, 8, 1'b0, 16);
    drive(0, 1'b0, 24);
    check("brk_fe", 32'(a_fe - f0), 32'd1);
    check("brk_dv", 32'(a_dv - d0), 32'd0);
    check("brk_bits", 32'(bits_of(0, sb, 8)), 32'h3C);
    check("brk_busy_low_line", 32'(a_busy), 32'd1);
    drive(0, 1'b1, 2);
    check("brk_busy_2clk", 32'(a_busy), 32'd1);
    drive(0, 1'b1, 1);
    check("brk_busy_idle", 32'(a_busy), 32'd0);
    drive(0, 1'b1, 6);

    // Reset after the 3rd shift strobe
    sb = a_sh_cyc.size(); d0 = a_dv; f0 = a_fe;
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 11);
    check("rst_third_shift", 32'(a_shift_en), 32'd1);
    check("rst_nshift_pre", 32'(a_sh_cyc.size() - sb), 32'd3);
    reset = 1'b1;
    rx_a  = 1'b1;
    @(negedge clk);
    check("rst_outs_zero", 32'(outs_a()), 32'h0);
    reset = 1'b0;
    drive(0, 1'b1, 40);
    check("rst_nshift_post", 32'(a_sh_cyc.size() - sb), 32'd3);
    check("rst_no_pulses", 32'((a_dv - d0) + (a_fe - f0)), 32'd0);
    sb = a_sh_cyc.size(); d0 = a_dv;
    send_frame(0, 8'h55, 8, 1'b1, 16);
    drive(0, 1'b1, 8);
    check("rst_55_bits", 32'(bits_of(0, sb, 8)), 32'h55);
    check("rst_55_dv", 32'(a_dv - d0), 32'd1);

    // Back-to-back 0x00, 0xFF
    sb = a_sh_cyc.size(); d0 = a_dv; f0 = a_fe;
    send_frame(0, 8'h00, 8, 1'b1, 16);
    send_frame(0, 8'hFF, 8, 1'b1, 16);
    drive(0, 1'b1, 8);
    check("b2b_nshift", 32'(a_sh_cyc.size() - sb), 32'd16);
    check("b2b_bits0", 32'(bits_of(0, sb, 8)), 32'h00);
    check("b2b_bits1", 32'(bits_of(0, sb + 8, 8)), 32'hFF);
    check("b2b_dv", 32'(a_dv - d0), 32'd2);
    check("b2b_fe", 32'(a_fe - f0), 32'd0);

    // 7-bit, 4 clk/bit instance, frame 0x2B
    sb = b_sh_cyc.size(); c0 = b_clr; d0 = b_dv; f0 = b_fe;
    send_frame(1, 8'h2B, 7, 1'b1, 4);
    drive(1, 1'b1, 6);
    check("b_clr", 32'(b_clr - c0), 32'd1);
    check("b_nshift", 32'(b_sh_cyc.size() - sb), 32'd7);
    check("b_bits", 32'(bits_of(1, sb, 7)), 32'h2B);
    check("b_gaps", 32'(bad_gaps(1, sb, 7, 4)), 32'd0);
    check("b_first_lat", 32'(b_sh_cyc[sb] - b_clr_cyc), 32'd4);
    check("b_dv", 32'(b_dv - d0), 32'd1);
    check("b_dv_lat", 32'(b_dv_cyc - b_sh_cyc[sb+6]), 32'd4);
    check("b_fe", 32'(b_fe - f0), 32'd0);
    check("b_busy_idle", 32'(b_busy), 32'd0);

    check("a_exclusive", 32'(a_excl), 32'd0);
    check("b_exclusive", 32'(b_excl), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART datapath.
- Watches the serial line and detects and qualifies the start bit.
- Times mid-bit sampling and issues one-cycle shift strobes to the external shift register, LSB first.
- Checks the stop bit and reports frame completion or framing error.
- Sits between the raw rx pin and the receive shift register / byte consumer.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit. Must be even and >= 4.
- DATA_BITS, 8, data bits per frame.
- CNT_W, 8, bit-timer width. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- shreg_clr  out  1  one-cycle pulse; clears the shift register at a qualified start.
- shift_en  out  1  one-cycle pulse; shift register captures shift_bit this cycle (latch = !shift_en downstream).
- shift_bit  out  1  sampled data bit; valid when shift_en=1.
- busy  out  1  high in every state except IDLE.
- data_valid  out  1  one-cycle pulse; frame received with a good stop bit, shift register holds the byte.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.

Behaviour:
- Clock and reset:
  - One clock only: clk. Reset is synchronous and active-high, named reset.
  - While reset=1 at a clk edge: state=IDLE, timer=0, bit_idx=0, sync flops=1.
  - Outputs held at reset: shreg_clr=0, shift_en=0, shift_bit=0, busy=0, data_valid=0, frame_err=0.
  - Reset mid-frame abandons the frame with no pulses; the next frame needs a fresh start edge.
- Synchroniser:
  - rx passes through two flops to give rx_s.
  - All decisions use rx_s; rx-to-rx_s latency is 2 clk.
- State IDLE: if rx_s=0, go to START with timer=0; otherwise stay.
- State START: timer increments each clk. At timer = CLKS_PER_BIT/2 - 1:
  - rx_s=0: go to DATA, pulse shreg_clr, timer=0, bit_idx=0.
  - rx_s=1: glitch rejected; go to IDLE with no pulses.
- State DATA: timer increments each clk. At timer = CLKS_PER_BIT - 1:
  - timer=0, shift_en=1, shift_bit=rx_s (registered, same cycle as shift_en).
  - bit_idx increments; after the sample with bit_idx = DATA_BITS-1, go to STOP with timer=0.
- State STOP: at timer = CLKS_PER_BIT - 1:
  - rx_s=1: pulse data_valid, go to IDLE.
  - rx_s=0: pulse frame_err, go to BREAK.
- State BREAK: stay until rx_s=1, then go to IDLE. No new start is accepted while the line is held low.
- Output timing and exclusivity:
  - shift_en, shreg_clr, data_valid and frame_err are registered single-cycle pulses and mutually exclusive.
  - Exactly DATA_BITS shift_en pulses per qualified frame, spaced exactly CLKS_PER_BIT clk apart.
  - busy is registered and asserts the cycle after IDLE is left.
- Back-to-back frames: a start bit immediately after the stop bit is detected. The IDLE->START transition happens the cycle after the IDLE re-entry.
- Timer: saturation never occurs within legal parameters; the timer is cleared on every state change.

Test Plan:
- CLKS_PER_BIT=16, rx frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> shreg_clr once, then 8 shift_en pulses 16 clk apart with shift_bit 1,0,1,0,0,1,0,1; data_valid once 16 clk after the last shift_en; frame_err never asserted.
- rx low for 4 clk then high -> START aborts at the half-bit sample; no shreg_clr/shift_en; busy returns to 0.
- Frame 0x3C with stop bit 0 and rx held low 40 clk -> frame_err once; no data_valid; busy stays 1 until 2 clk after rx rises, then IDLE.
- reset pulsed for 1 clk after the 3rd shift_en -> all outputs 0 next cycle; no further shift_en; next frame 0x55 received cleanly with data_valid.
- Two frames 0x00 then 0xFF with zero idle gap -> 16 shift_en total, bits 0x8 then 1x8, two data_valid pulses, no frame_err.
- DATA_BITS=7, CLKS_PER_BIT=4, frame 0x2B -> 7 shift_en 4 clk apart with bits 1,1,0,1,0,1,0; data_valid once.
